// File: rtl/add16_pipe.sv
// Two-stage pipelined 16-bit signed adder/subtractor with saturating, wrapping and
// packed 4-bit-lane (PADDSB) modes, built from four cla_4bit slices plus group lookahead.

module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] c,
  output logic [3:0] p,
  output logic       gp,
  output logic       gg
);
  logic [3:0] g;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    gp   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

module add16_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_v
);
  localparam int DATA_W = 16;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PADD = 2'b10;
  localparam logic [1:0] OP_WRAP = 2'b11;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [DATA_W-1:0] raw,
                                                     input logic a_msb, input logic ovf);
    if (!ovf) return raw;
    return a_msb ? 16'sh8000 : 16'sh7FFF;
  endfunction

  function automatic logic [3:0] sat_lane(input logic [3:0] raw, input logic a_msb,
                                          input logic ovf);
    if (!ovf) return raw;
    return a_msb ? 4'h8 : 4'h7;
  endfunction

  logic                     vld_p1_q, vld_p1_d;
  logic [1:0]               op_p1_q, op_p1_d;
  logic signed [DATA_W-1:0] a_p1_q, a_p1_d;
  logic signed [DATA_W-1:0] bp_p1_q, bp_p1_d;

  logic                     vld_p2_q, vld_p2_d;
  logic signed [DATA_W-1:0] result_p2_q, result_p2_d;
  logic                     n_p2_q, n_p2_d;
  logic                     z_p2_q, z_p2_d;
  logic                     v_p2_q, v_p2_d;

  logic adv2, accept;

  logic [3:0][3:0]          p_s, c_s;
  logic [3:0]               gp_s, gg_s, cin_s;
  logic                     c16;
  logic signed [DATA_W-1:0] raw, res;
  logic [3:0]               lane_ovf;
  logic                     ovf, n_res, z_res;

  always_comb begin
    adv2     = vld_p1_q & (!vld_p2_q | out_ready);
    in_ready = !vld_p1_q | adv2;
    accept   = in_valid & in_ready;
  end

  // ---- stage 1 capture: operands with B pre-inverted for subtract
  always_comb begin
    vld_p1_d = vld_p1_q;
    op_p1_d  = op_p1_q;
    a_p1_d   = a_p1_q;
    bp_p1_d  = bp_p1_q;
    if (accept) begin
      vld_p1_d = 1'b1;
      op_p1_d  = op;
      a_p1_d   = a;
      bp_p1_d  = (op == OP_SUB) ? ~b : b;
    end else if (adv2) begin
      vld_p1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p1_d;
    op_p1_q <= op_p1_d;
    a_p1_q  <= a_p1_d;
    bp_p1_q <= bp_p1_d;
  end

  for (genvar i = 0; i < 4; i++) begin : g_slice
    cla_4bit u_cla (
      .a  (a_p1_q[4*i +: 4]),
      .b  (bp_p1_q[4*i +: 4]),
      .cin(cin_s[i]),
      .c  (c_s[i]),
      .p  (p_s[i]),
      .gp (gp_s[i]),
      .gg (gg_s[i])
    );
  end

  // Group P/G do not depend on slice cin, so this lookahead has no loop through the slices.
  always_comb begin
    cin_s = '0;
    if (op_p1_q != OP_PADD) begin
      cin_s[0] = (op_p1_q == OP_SUB);
      cin_s[1] = gg_s[0] | (gp_s[0] & cin_s[0]);
      cin_s[2] = gg_s[1] | (gp_s[1] & cin_s[1]);
      cin_s[3] = gg_s[2] | (gp_s[2] & cin_s[2]);
    end
    c16 = gg_s[3] | (gp_s[3] & cin_s[3]);
  end

  // ---- stage 2: mode handling, flags
  always_comb begin
    raw      = p_s ^ c_s;
    res      = raw;
    lane_ovf = '0;
    ovf      = 1'b0;
    if (op_p1_q == OP_PADD) begin
      for (int i = 0; i < 4; i++) begin
        lane_ovf[i] = (a_p1_q[4*i+3] == bp_p1_q[4*i+3]) & (raw[4*i+3] != a_p1_q[4*i+3]);
        res[4*i +: 4] = sat_lane(raw[4*i +: 4], a_p1_q[4*i+3], lane_ovf[i]);
      end
      ovf = |lane_ovf;
    end else begin
      // carry-in vs carry-out of the sign bit: equivalent to the operand/result sign test
      ovf = c16 ^ c_s[3][3];
      res = (op_p1_q == OP_WRAP) ? raw : sat16(raw, a_p1_q[15], ovf);
    end
    n_res = (op_p1_q != OP_PADD) & res[15];
    z_res = (res == '0);
  end

  always_comb begin
    vld_p2_d    = vld_p2_q;
    result_p2_d = result_p2_q;
    n_p2_d      = n_p2_q;
    z_p2_d      = z_p2_q;
    v_p2_d      = v_p2_q;
    if (adv2) begin
      vld_p2_d    = 1'b1;
      result_p2_d = res;
      n_p2_d      = n_res;
      z_p2_d      = z_res;
      v_p2_d      = ovf;
    end else if (out_ready) begin
      vld_p2_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q    <= 1'b0;
      result_p2_q <= '0;
      n_p2_q      <= 1'b0;
      z_p2_q      <= 1'b0;
      v_p2_q      <= 1'b0;
    end else begin
      vld_p2_q    <= vld_p2_d;
      result_p2_q <= result_p2_d;
      n_p2_q      <= n_p2_d;
      z_p2_q      <= z_p2_d;
      v_p2_q      <= v_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign result    = result_p2_q;
  assign flag_n    = n_p2_q;
  assign flag_z    = z_p2_q;
  assign flag_v    = v_p2_q;

endmodule

// File: tb/tb_add16_pipe.sv
// Scoreboard bench for add16_pipe: driver pushes hand-computed expectations on accept,
// a negedge monitor pops and compares every consumed result and checks hold under stall.

module tb_add16_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_n, flag_z, flag_v;

  int tests = 0;
  int fails = 0;

  logic [18:0] exp_q[$];

  localparam int NV = 15;
  logic [15:0] va[NV], vb[NV], vres[NV];
  logic [1:0]  vop[NV];
  logic [2:0]  vnzv[NV];

  add16_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .flag_v   (flag_v)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  logic        stall_prev = 1'b0;
  logic [18:0] held = '0;

  always @(negedge clk) begin
    if (stall_prev)
      chk("hold", {12'h0, out_valid, result, flag_n, flag_z, flag_v}, {12'h0, 1'b1, held});
    stall_prev = out_valid & !out_ready & !rst;
    held       = {result, flag_n, flag_z, flag_v};
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {13'h0, result, flag_n, flag_z, flag_v}, 32'hFFFF_FFFF);
      end else begin
        chk("result_nzv", {13'h0, result, flag_n, flag_z, flag_v}, {13'h0, exp_q.pop_front()});
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input int idx);
    int  guard = 0;
    bit  acc   = 0;
    in_valid = 1'b1;
    a  = va[idx];
    b  = vb[idx];
    op = vop[idx];
    while (!acc) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        exp_q.push_back({vres[idx], vnzv[idx]});
      end
      @(posedge clk); #1;
      guard++;
      if (!acc && guard > 200) begin
        chk("send_timeout", 32'(guard), 32'd0);
        acc = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic latency_check(input int idx);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a  = va[idx];
    b  = vb[idx];
    op = vop[idx];
    @(negedge clk);
    chk("lat_in_ready", {31'h0, in_ready}, 32'd1);
    exp_q.push_back({vres[idx], vnzv[idx]});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_edge1_valid", {31'h0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", {31'h0, out_valid}, 32'd1);
    chk("lat_edge2_result", {16'h0, result}, {16'h0, vres[idx]});
    @(posedge clk); #1;
    chk("lat_edge3_valid", {31'h0, out_valid}, 32'd0);
  endtask

  initial begin
    //        a          b          op     result     {n,z,v}
    va[0]  = 16'h7FFF; vb[0]  = 16'h0001; vop[0]  = 2'b00; vres[0]  = 16'h7FFF; vnzv[0]  = 3'b001;
    va[1]  = 16'h8000; vb[1]  = 16'h0001; vop[1]  = 2'b01; vres[1]  = 16'h8000; vnzv[1]  = 3'b101;
    va[2]  = 16'h7FFF; vb[2]  = 16'h0001; vop[2]  = 2'b11; vres[2]  = 16'h8000; vnzv[2]  = 3'b101;
    va[3]  = 16'h7F18; vb[3]  = 16'h1198; vop[3]  = 2'b10; vres[3]  = 16'h70A8; vnzv[3]  = 3'b001;
    va[4]  = 16'h1234; vb[4]  = 16'h1234; vop[4]  = 2'b01; vres[4]  = 16'h0000; vnzv[4]  = 3'b010;
    va[5]  = 16'h0FFF; vb[5]  = 16'h0001; vop[5]  = 2'b00; vres[5]  = 16'h1000; vnzv[5]  = 3'b000;
    va[6]  = 16'h1234; vb[6]  = 16'h1111; vop[6]  = 2'b00; vres[6]  = 16'h2345; vnzv[6]  = 3'b000;
    va[7]  = 16'h0005; vb[7]  = 16'h0007; vop[7]  = 2'b01; vres[7]  = 16'hFFFE; vnzv[7]  = 3'b100;
    va[8]  = 16'h8000; vb[8]  = 16'hFFFF; vop[8]  = 2'b00; vres[8]  = 16'h8000; vnzv[8]  = 3'b101;
    va[9]  = 16'h8000; vb[9]  = 16'hFFFF; vop[9]  = 2'b11; vres[9]  = 16'h7FFF; vnzv[9]  = 3'b001;
    va[10] = 16'h0000; vb[10] = 16'h0000; vop[10] = 2'b10; vres[10] = 16'h0000; vnzv[10] = 3'b010;
    va[11] = 16'h8123; vb[11] = 16'h0000; vop[11] = 2'b10; vres[11] = 16'h8123; vnzv[11] = 3'b000;
    va[12] = 16'h7FFF; vb[12] = 16'hFFFF; vop[12] = 2'b01; vres[12] = 16'h7FFF; vnzv[12] = 3'b001;
    va[13] = 16'hFFFF; vb[13] = 16'h0001; vop[13] = 2'b11; vres[13] = 16'h0000; vnzv[13] = 3'b010;
    va[14] = 16'h8000; vb[14] = 16'h7FFF; vop[14] = 2'b01; vres[14] = 16'h8000; vnzv[14] = 3'b101;

    // Reset held two cycles with a beat offered
    rst = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; op = 2'b00; out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
      chk("rst_result", {16'h0, result}, 32'd0);
      chk("rst_flags", {29'h0, flag_n, flag_z, flag_v}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_no_output", {31'h0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back stream at full throughput
    for (int i = 0; i < NV; i++) send(i);
    drain();

    latency_check(5);

    // Backpressure: four beats while the consumer stalls
    fork
      begin
        for (int i = 6; i < 10; i++) send(i);
      end
      begin
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", {31'h0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
        chk("bp_first_beat", {16'h0, result}, {16'h0, vres[6]});
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Stream under an irregular consumer
    fork
      begin
        for (int i = 0; i < NV; i++) send(i);
      end
      begin
        logic [39:0] pat;
        pat = 40'hA5_C396_F03B;
        for (int k = 0; k < 40; k++) begin
          out_ready = pat[k];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(0);
    send(3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("midrst_result", {16'h0, result}, 32'd0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'd1);
    out_ready = 1'b1;
    latency_check(14);
    repeat (4) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
